line_buffer_scheduler: RTL

- Controls the quad-bank scan-line image RAM that sits between the log/low-pass envelope stage and the SPI readout.
- Write side: decimates envelope samples into line addresses, gates writes by focal segment, and rotates the write bank once per line.
- Read side: grants the SPI reader the two most recently completed lines and locks those banks until the read finishes. A line that would overwrite a locked bank is dropped and counted.

---
 rtl/line_buffer_scheduler.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/line_buffer_scheduler.sv
// Quad-bank scan-line RAM scheduler: decimated, segment-gated writes on
// one side, locked line-pair grants for the SPI reader on the other.
module line_buffer_scheduler #(
  parameter int ADDR_W     = 9,
  parameter int NEAR_LIMIT = 2000,
  parameter int SAMPLE_MAX = 16000
) (
  input  logic              clk_50M,
  input  logic              reset_n,
  input  logic              line_start,
  input  logic [1:0]        focus_num,
  input  logic [1:0]        zoom,
  input  logic              lf_valid,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [1:0]        wr_bank,
  input  logic              rd_req,
  input  logic              rd_step,
  output logic              rd_grant,
  output logic [1:0]        rd_bank_a,
  output logic [1:0]        rd_bank_b,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_done,
  output logic [7:0]        overrun_cnt
);

  typedef enum logic [1:0] {
    W_IDLE,
    W_FILL,
    W_DONE
  } wst_t;

  typedef enum logic {
    R_IDLE,
    R_ACTIVE
  } rst_t;

  localparam logic [ADDR_W-1:0] AMAX = '1;
  localparam logic [15:0] NEAR = 16'(NEAR_LIMIT);
  localparam logic [15:0] SMAX = 16'(SAMPLE_MAX);

  wst_t              wst_q, wst_d;
  rst_t              rst_q, rst_d;
  logic [1:0]        wr_bank_q, wr_bank_d;
  logic [1:0]        last_q, last_d;
  logic [1:0]        pub_q, pub_d;
  logic [7:0]        ovr_q, ovr_d;
  logic [7:0]        dec_n_q, dec_n_d;
  logic [7:0]        dec_cnt_q, dec_cnt_d;
  logic [15:0]       smp_q, smp_d;
  logic [ADDR_W-1:0] fill_q, fill_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [3:0]        lock_q, lock_d;
  logic              grant_q, grant_d;
  logic              done_q, done_d;
  logic [1:0]        bank_a_q, bank_a_d;
  logic [1:0]        bank_b_q, bank_b_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;

  logic [1:0] nxt_bank;
  logic [1:0] prev_bank;
  logic       seg_ok;

  assign nxt_bank  = wr_bank_q + 2'd1;
  assign prev_bank = last_q - 2'd1;
  assign seg_ok    = (smp_q <= NEAR && focus_num == 2'd0) ||
                     (smp_q >  NEAR && focus_num == 2'd3);

  always_comb begin
    wst_d     = wst_q;
    wr_bank_d = wr_bank_q;
    last_d    = last_q;
    pub_d     = pub_q;
    ovr_d     = ovr_q;
    dec_n_d   = dec_n_q;
    dec_cnt_d = dec_cnt_q;
    smp_d     = smp_q;
    fill_d    = fill_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    if (line_start) begin
      wst_d     = W_FILL;
      dec_cnt_d = '0;
      smp_d     = '0;
      fill_d    = '0;
      wr_addr_d = '0;
      unique case (zoom)
        2'd0: dec_n_d = 8'd10;
        2'd1: dec_n_d = 8'd15;
        2'd2: dec_n_d = 8'd19;
        2'd3: dec_n_d = 8'd24;
      endcase
      // Lock state here is pre-grant/pre-release by construction.
      if (wst_q != W_IDLE) begin
        if (!lock_q[nxt_bank]) begin
          last_d    = wr_bank_q;
          wr_bank_d = nxt_bank;
          pub_d     = (pub_q == 2'd2) ? 2'd2 : pub_q + 2'd1;
        end else if (ovr_q != 8'hFF) begin
          ovr_d = ovr_q + 8'd1;
        end
      end
    end else if (wst_q == W_FILL && lf_valid) begin
      wr_en_d   = seg_ok;
      wr_addr_d = fill_q;
      if (smp_q < SMAX) smp_d = smp_q + 16'd1;
      if (dec_cnt_q < dec_n_q) begin
        dec_cnt_d = dec_cnt_q + 8'd1;
      end else begin
        dec_cnt_d = '0;
        if (fill_q == AMAX) wst_d = W_DONE;
        else fill_d = fill_q + 1'b1;
      end
    end
  end

  always_comb begin
    rst_d     = rst_q;
    grant_d   = 1'b0;
    done_d    = 1'b0;
    bank_a_d  = bank_a_q;
    bank_b_d  = bank_b_q;
    rd_addr_d = rd_addr_q;
    lock_d    = lock_q;
    // Locks drop only after the done cycle so a coincident line_start
    // still sees them held.
    if (done_q) lock_d = '0;
    unique case (rst_q)
      R_IDLE: begin
        if (rd_req && pub_q == 2'd2) begin
          grant_d           = 1'b1;
          bank_a_d          = last_q;
          bank_b_d          = prev_bank;
          rd_addr_d         = '0;
          lock_d[last_q]    = 1'b1;
          lock_d[prev_bank] = 1'b1;
          rst_d             = R_ACTIVE;
        end
      end
      R_ACTIVE: begin
        if (rd_step) begin
          if (rd_addr_q == AMAX) begin
            done_d = 1'b1;
            rst_d  = R_IDLE;
          end else begin
            rd_addr_d = rd_addr_q + 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_50M or negedge reset_n) begin
    if (!reset_n) begin
      wst_q     <= W_IDLE;
      rst_q     <= R_IDLE;
      wr_bank_q <= '0;
      last_q    <= '0;
      pub_q     <= '0;
      ovr_q     <= '0;
      dec_n_q   <= '0;
      dec_cnt_q <= '0;
      smp_q     <= '0;
      fill_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      lock_q    <= '0;
      grant_q   <= 1'b0;
      done_q    <= 1'b0;
      bank_a_q  <= '0;
      bank_b_q  <= '0;
      rd_addr_q <= '0;
    end else begin
      wst_q     <= wst_d;
      rst_q     <= rst_d;
      wr_bank_q <= wr_bank_d;
      last_q    <= last_d;
      pub_q     <= pub_d;
      ovr_q     <= ovr_d;
      dec_n_q   <= dec_n_d;
      dec_cnt_q <= dec_cnt_d;
      smp_q     <= smp_d;
      fill_q    <= fill_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      lock_q    <= lock_d;
      grant_q   <= grant_d;
      done_q    <= done_d;
      bank_a_q  <= bank_a_d;
      bank_b_q  <= bank_b_d;
      rd_addr_q <= rd_addr_d;
    end
  end

  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_bank     = wr_bank_q;
  assign rd_grant    = grant_q;
  assign rd_bank_a   = bank_a_q;
  assign rd_bank_b   = bank_b_q;
  assign rd_addr     = rd_addr_q;
  assign rd_done     = done_q;
  assign overrun_cnt = ovr_q;

endmodule
